// File: rtl/seq_alu_acc.sv
// seq_alu_acc: accumulator ALU with a start/busy/done handshake.
// Operand A comes from the port, operand B is the low DATA_W bits of the
// accumulator. Single-cycle ops complete on the accepting edge. Multiply is a
// DATA_W-iteration shift-add that works on operands latched at the start.
module seq_alu_acc #(
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] a,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ACC_W-1:0]  acc_q
);

    localparam int          CNT_W   = $clog2(DATA_W + 1);
    localparam int          PROD_W  = 2 * DATA_W;
    localparam logic [31:0] ACC_W_U = ACC_W;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   op_b;
    logic [ACC_W-1:0]    b_ext;
    logic [ACC_W:0]      acc_sum;
    logic                shift_oob;
    logic [ACC_W-1:0]    alu_res;
    logic                alu_carry;
    logic [PROD_W-1:0]   prod_step;

    assign op_b      = acc_q[DATA_W-1:0];
    assign b_ext     = ACC_W'(op_b);
    // Carry-out of the accumulate is the extra top bit of a one-wider sum.
    assign acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(a);
    // Shift distances at or beyond the accumulator width flush to zero.
    assign shift_oob = (32'(a) >= ACC_W_U);
    // One shift-add iteration: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

    // Single-cycle ALU result for every opcode except multiply.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (func)
            3'b001: alu_res[PROD_W-1:0] = {a | op_b, a ^ op_b};
            3'b010: alu_res[DATA_W:0]   = {1'b0, a} + {1'b0, op_b};
            3'b011: begin
                alu_carry = acc_sum[ACC_W];
                if (acc_sum[ACC_W] && (SATURATE != 0)) begin
                    alu_res = '1;
                end else begin
                    alu_res = acc_sum[ACC_W-1:0];
                end
            end
            3'b100: alu_res[DATA_W:0]   = {1'b0, a} + (DATA_W + 1)'(1);
            3'b101: alu_res[0]          = |{a, op_b};
            3'b110: alu_res = shift_oob ? '0 : (b_ext << a);
            3'b111: alu_res = shift_oob ? '0 : (b_ext >> a);
            default: alu_res = '0;
        endcase
    end

    // Next-state logic: accept requests in IDLE, iterate the multiplier in MUL.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (func == 3'b000) begin
                        mcand_d  = PROD_W'(a);
                        mplier_d = op_b;
                        prod_d   = '0;
                        cnt_d    = CNT_W'(DATA_W);
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else begin
                        acc_d  = alu_res;
                        done_d = 1'b1;
                        if (func == 3'b011) begin
                            ovf_d = alu_carry;
                        end
                    end
                end
            end
            MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    acc_d   = ACC_W'(prod_step);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any multiply in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/seq_alu_acc.md
Name: seq_alu_acc

Overview:
Parametrised accumulator ALU, the successor to the lab single-cycle ALU+register datapath. Operand A comes from outside. Operand B is the low DATA_W bits of the internal accumulator. Adds a start/busy/done handshake, a multi-cycle shift-add multiplier, an accumulate op with optional saturation, and an overflow flag. Sits between switch/key input logic and the hex/LED display decoders.

Parameters:
DATA_W, 4, operand A/B width (>=2)
ACC_W, 8, accumulator/result width; must satisfy ACC_W >= 2*DATA_W
SATURATE, 0, 1 = op 011 clamps to all-ones on carry-out; 0 = wraps modulo 2^ACC_W

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled each rising edge, accepted only when busy=0
func  input  3  opcode, sampled with accepted start
a  input  DATA_W  operand A, sampled with accepted start
busy  output  1  multiplier in progress
done  output  1  one-cycle pulse: acc_q updated by the accepted op
ovf  output  1  carry-out flag of last op 011
acc_q  output  ACC_W  accumulator contents

Behaviour:
- Reset (clock edge with reset=1): acc_q=0, busy=0, done=0, ovf=0, FSM->IDLE. Reset overrides start and aborts any multiply; the partial product is discarded.
- B = acc_q[DATA_W-1:0]. All results are zero-extended to ACC_W.
- FSM states: IDLE, MUL.
- IDLE:
  - start=1 at edge E0 with func != 000: acc_q <= result at E0, done=1 for the following cycle, stay IDLE.
  - start=1 with func=000: latch a and B into internal operand regs, clear the partial product, load iteration counter=DATA_W, busy<=1, ->MUL.
- MUL: one shift-add iteration per edge (E1..E_DATA_W), using latched operands only; changes on a or acc_q have no effect. At E_DATA_W: acc_q <= A*B (2*DATA_W bits, zero-extended), busy<=0, done<=1 for one cycle, ->IDLE. Latency DATA_W cycles, busy high exactly DATA_W cycles.
- start while busy=1 is ignored (not queued). done is never high while busy is high. start at the edge where done rises is accepted normally (back-to-back issue allowed).
- Opcodes:
  - 000: A*B, multi-cycle.
  - 001: {A|B, A^B}.
  - 010: A+B, DATA_W+1 bits.
  - 011: accumulate, acc_q + zext(A) at ACC_W width.
    - carry-out=1: ovf<=1; result = all-ones if SATURATE=1, else wrapped sum.
    - carry-out=0: ovf<=0.
  - 100: A+1, DATA_W+1 bits.
  - 101: logical OR, 1 if A!=0 or B!=0, else 0.
  - 110: zext(B) << A. Result is 0 if A >= ACC_W.
  - 111: zext(B) >> A. Result is 0 if A >= ACC_W.
- ovf changes only on an accepted op 011 or reset; every other op leaves it unchanged.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
(all with DATA_W=4, ACC_W=8 unless noted)
1. Reset, then idle 5 cycles -> acc_q=0x00, busy=0, done=0, ovf=0 throughout; assert reset mid-run -> same values one edge later.
2. start func=010 a=0xF -> acc_q=0x0F next cycle, done pulses 1 cycle. Then start func=000 a=0xF -> busy=1 for exactly 4 cycles; acc_q=0xE1 when done pulses; acc_q unchanged before that.
3. From acc_q=0xE1: func=011 a=0xF -> 0xF0, ovf=0; func=011 a=0xF -> 0xFF, ovf=0; func=011 a=0x1 -> SATURATE=1: 0xFF, ovf=1; SATURATE=0: 0x00, ovf=1.
4. acc_q=0x03: func=110 a=2 -> 0x0C; then func=111 a=2 -> 0x03; then func=110 a=9 -> 0x00. Separately, acc_q=0x03 with func=001 a=0x5 -> 0x76; func=101 a=0 -> 0x01.
5. During multiply (acc_q=0x03, func=000 a=0x5): toggle a and pulse start with func=010 while busy -> ignored; result 0x0F; exactly one done pulse.
6. Reset asserted in 2nd cycle of a multiply -> next edge acc_q=0, busy=0, done=0, no later done pulse; a new start after reset is accepted normally.
